pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational carry-in adder.
- Splits a WIDTH-bit add/subtract into STAGE_WIDTH-bit slices, one slice per pipeline stage, with the carry rippling stage-to-stage through registers.
- Sustains one operation per clock with valid/ready flow control, and reports carry-out and signed overflow.
- Used wherever wide adds must close timing at full clock rate (accumulators, address generators, datapath tests).

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of STAGE_WIDTH and >= STAGE_WIDTH.
STAGE_WIDTH, 8, bits added per pipeline stage; STAGES = WIDTH/STAGE_WIDTH is the pipeline depth.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands on x/y/carry_in/sub are valid.
in_ready  output  1  block can accept an operation this cycle.
x  input  WIDTH  operand A, unsigned/two's-complement.
y  input  WIDTH  operand B.
carry_in  input  1  carry into bit 0.
sub  input  1  0: add; 1: add bitwise-inverted y.
out_valid  output  1  sum/carry_out/overflow hold a result.
out_ready  input  1  consumer accepts the result this cycle.
sum  output  WIDTH  result bits [WIDTH-1:0].
carry_out  output  1  result bit WIDTH (carry out of MSB).
overflow  output  1  signed overflow of the operation.

Behaviour:
- Arithmetic: B = sub ? ~y : y; full result = x + B + carry_in, computed modulo 2^(WIDTH+1).
  - sum = low WIDTH bits; carry_out = bit WIDTH.
  - sub=1 with carry_in=1 yields x - y; carry_out=1 then means no borrow.
  - overflow = (x[MSB] == B[MSB]) && (sum[MSB] != x[MSB]).
- Pipeline: STAGES register stages.
  - Stage k (0..STAGES-1) adds slice k of x and B plus the carry registered out of stage k-1 (stage 0 uses carry_in).
  - Not-yet-added upper slices are carried forward (skewed) with the operation.
  - Already-computed lower sum slices are carried forward (deskewed) with the operation.
  - No combinational carry path spans more than STAGE_WIDTH bits.
- Each stage holds a valid bit. The output register is the last stage.
- Flow control:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance=1, all stages shift one position. Stage 0 captures the input if in_valid, otherwise a bubble (valid=0).
  - When advance=0, every stage holds its contents, including bubbles.
  - An input transfer occurs on in_valid && in_ready; an output transfer on out_valid && out_ready.
- Latency: STAGES cycles from input transfer to out_valid with no backpressure. Throughput: 1 op/cycle.
  - Example: accepted at edge n, out_valid is high after edge n+STAGES-1, i.e. in cycle n+STAGES.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated under any out_ready pattern.
- Output stability: while out_valid=1 and out_ready=0, sum/carry_out/overflow are held constant.
- Simultaneous events: with a full pipeline and out_ready=1, the output transfer and an input transfer occur in the same cycle.
- STAGES=1: the block degenerates to a single registered adder with the same handshake.
- Reset:
  - While rst=1 at a clock edge, all stage valid bits and out_valid clear; sum, carry_out and overflow reset to 0.
  - in_ready=1 in the cycle after reset deasserts.
  - Operations in flight when reset asserts are discarded.
  - An input presented while rst=1 is not accepted.
- Data registers other than outputs need no reset.

Test Plan:
- Latency (WIDTH=32, STAGE_WIDTH=8): accept x=0x0000_00FF, y=0x0000_0001, carry_in=0, sub=0 at edge n, out_ready=1 -> out_valid first high in cycle n+4; sum=0x0000_0100, carry_out=0, overflow=0.
- Full ripple across all stages: x=0xFFFF_FFFF, y=0, carry_in=1 -> sum=0, carry_out=1, overflow=0. Then x=0x7FFF_FFFF, y=1 -> sum=0x8000_0000, carry_out=0, overflow=1.
- Subtract: x=5, y=7, sub=1, carry_in=1 -> sum=0xFFFF_FFFE, carry_out=0. Then x=7, y=5 -> sum=2, carry_out=1. Then x=0x8000_0000, y=1 -> sum=0x7FFF_FFFF, overflow=1.
- Backpressure: stream 20 random ops back-to-back with random in_valid, holding out_ready=0 for 6 cycles mid-stream -> in_ready drops, held output is stable, and all 20 results match the reference model in order with none lost.
- Throughput: in_valid and out_ready held high for 100 cycles -> 100 accepted, and after fill one result per cycle with no bubbles.
- Reset mid-operation: 3 ops in flight, assert rst for 1 cycle -> out_valid=0, sum=0 next cycle, in-flight ops never emerge, and the next accepted op returns correctly after 4 cycles.

Source files
------------

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGE_WIDTH-bit slices, one slice per stage, valid/ready flow.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int STAGE_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int S = WIDTH / STAGE_WIDTH;
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < S; k++) begin : st
    localparam int LO = k * STAGE_WIDTH;
    logic [WIDTH-1:LO] xi, bi;
    logic ci, vi, v_q, c_q;
    logic [STAGE_WIDTH:0] r;
    logic [LO+STAGE_WIDTH-1:0] s_d, s_q;
    if (k == 0) begin : head
      assign xi = x;
      assign bi = sub ? ~y : y;
      assign ci = carry_in;
      assign vi = in_valid;
      assign s_d = r[STAGE_WIDTH-1:0];
    end else begin : body
      assign xi = st[k-1].fwd.x_q;
      assign bi = st[k-1].fwd.b_q;
      assign ci = st[k-1].c_q;
      assign vi = st[k-1].v_q;
      assign s_d = {r[STAGE_WIDTH-1:0], st[k-1].s_q};
    end
    assign r = {1'b0, xi[LO +: STAGE_WIDTH]} + {1'b0, bi[LO +: STAGE_WIDTH]} + {{STAGE_WIDTH{1'b0}}, ci};
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vi;
        c_q <= r[STAGE_WIDTH];
        s_q <= s_d;
      end
    end
    if (k < S - 1) begin : fwd
      // only the slices still to be added travel on with the operation
      logic [WIDTH-1:LO+STAGE_WIDTH] x_q, b_q;
      always_ff @(posedge clk) begin
        if (adv) begin
          x_q <= xi[WIDTH-1:LO+STAGE_WIDTH];
          b_q <= bi[WIDTH-1:LO+STAGE_WIDTH];
        end
      end
    end else begin : last
      logic ov_q;
      always_ff @(posedge clk) begin
        if (rst) ov_q <= 1'b0;
        else if (adv) ov_q <= (xi[WIDTH-1] == bi[WIDTH-1]) && (s_d[WIDTH-1] != xi[WIDTH-1]);
      end
    end
  end
  assign out_valid = st[S-1].v_q;
  assign sum = st[S-1].s_q;
  assign carry_out = st[S-1].c_q;
  assign overflow = st[S-1].last.ov_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder against a whole-width arithmetic model.
module tb_pipelined_adder;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, carry_in = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [W-1:0] x = '0, y = '0;
  logic in_ready, out_valid, carry_out, overflow;
  logic [W-1:0] sum;
  int tests = 0, fails = 0, acc = 0;
  logic [W+1:0] exp_q[$], got_q[$];

  pipelined_adder #(.WIDTH(W), .STAGE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .carry_in(carry_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // {overflow, carry_out, sum} straight from the arithmetic definition
  function automatic logic [W+1:0] ref_op(logic [W-1:0] a, logic [W-1:0] yv, logic c, logic s);
    logic [W-1:0] b;
    logic [W:0] full;
    b = s ? ~yv : yv;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return {(a[W-1] == b[W-1]) && (full[W-1] != a[W-1]), full};
  endfunction

  task automatic tick();
    #1;
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(ref_op(x, y, carry_in, sub));
      acc++;
    end
    if (out_valid && out_ready) got_q.push_back({overflow, carry_out, sum});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic c, logic s);
    x = a; y = b; carry_in = c; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic clear();
    exp_q.delete();
    got_q.delete();
    acc = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || sum !== '0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got v=%b s=%h c=%b o=%b want all 0", out_valid, sum, carry_out, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    int lat = 0;
    clear();
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL latency: got %0d edges after accept want 3", lat);
    end
    tests++;
    if ({overflow, carry_out, sum} !== 34'h0_0000_0100) begin
      fails++;
      $display("FAIL latency_value: got %h want %h", {overflow, carry_out, sum}, 34'h0_0000_0100);
    end
    drain();
  endtask

  task automatic test_ripple();
    clear();
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    drain();
    tests++;
    if (got_q.size() != 2) begin
      fails++;
      $display("FAIL ripple_count: got %0d want 2", got_q.size());
    end else begin
      tests++;
      if (got_q[0] !== 34'h1_0000_0000) begin
        fails++;
        $display("FAIL ripple_carry: got %h want %h", got_q[0], 34'h1_0000_0000);
      end
      tests++;
      if (got_q[1] !== 34'h2_8000_0000) begin
        fails++;
        $display("FAIL ripple_overflow: got %h want %h", got_q[1], 34'h2_8000_0000);
      end
    end
  endtask

  task automatic test_subtract();
    logic [W+1:0] want [3];
    want[0] = 34'h0_FFFF_FFFE;
    want[1] = 34'h1_0000_0002;
    want[2] = 34'h3_7FFF_FFFF;
    clear();
    send(32'd5, 32'd7, 1'b1, 1'b1);
    send(32'd7, 32'd5, 1'b1, 1'b1);
    send(32'h8000_0000, 32'd1, 1'b1, 1'b1);
    drain();
    tests++;
    if (got_q.size() != 3) begin
      fails++;
      $display("FAIL sub_count: got %0d want 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got_q[i] !== want[i]) begin
          fails++;
          $display("FAIL sub_%0d: got %h want %h", i, got_q[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0, left = 6, drops = 0;
    bit started = 0, prev_stall = 0;
    logic [W+1:0] cur, prev_val = '0;
    clear();
    while (acc < 20 && cyc < 300) begin
      if (!started && out_valid && acc >= 5) started = 1;
      out_ready = !(started && left > 0);
      if (started && left > 0) left--;
      in_valid = ($urandom_range(0, 3) != 0);
      x = $urandom; y = $urandom; carry_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      cur = {overflow, carry_out, sum};
      if (prev_stall) begin
        tests++;
        if (!out_valid || cur !== prev_val) begin
          fails++;
          $display("FAIL hold_stable: got v=%b %h want v=1 %h", out_valid, cur, prev_val);
        end
      end
      if (out_valid && !out_ready) begin
        drops++;
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_val = cur;
      tick();
      cyc++;
    end
    drain();
    tests++;
    if (drops != 6) begin
      fails++;
      $display("FAIL stall_cycles: got %0d want 6", drops);
    end
    tests++;
    if (got_q.size() != 20 || exp_q.size() != 20) begin
      fails++;
      $display("FAIL bp_count: got %0d results of %0d accepted want 20", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL bp_result_%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_throughput();
    int first = -1, bubbles = 0;
    clear();
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1;
      x = $urandom; y = $urandom; carry_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && first < 0) first = c;
      if (first >= 0 && !out_valid) bubbles++;
      tick();
    end
    drain();
    tests++;
    if (acc != 100 || first != 4 || bubbles != 0) begin
      fails++;
      $display("FAIL throughput: got acc=%0d first=%0d bubbles=%0d want 100 4 0", acc, first, bubbles);
    end
    tests++;
    if (got_q.size() != 100) begin
      fails++;
      $display("FAIL tp_count: got %0d want 100", got_q.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL tp_result_%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    clear();
    out_ready = 1'b1;
    repeat (3) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || sum !== '0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b s=%h want 0 0", out_valid, sum);
    end
    rst = 1'b0;
    clear();
    repeat (8) tick();
    tests++;
    if (got_q.size() != 0) begin
      fails++;
      $display("FAIL flushed: got %0d stale results want 0", got_q.size());
    end
    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    tests++;
    if (lat != 3 || exp_q.size() != 1) begin
      fails++;
      $display("FAIL post_reset_latency: got %0d edges, %0d accepted want 3 1", lat, exp_q.size());
    end else begin
      tests++;
      if ({overflow, carry_out, sum} !== exp_q[0]) begin
        fails++;
        $display("FAIL post_reset_value: got %h want %h", {overflow, carry_out, sum}, exp_q[0]);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ripple();
    test_subtract();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
